// File: rtl/ulight_fifo_txclk_div.sv
// Power-of-two rate divider producing a one-cycle tick for the SpaceWire transmitter.
// Optional select debounce is compiled in with `define ULIGHT_TXCLK_DIV_DEBOUNCE_EN.
module ulight_fifo_txclk_div #(
  parameter logic [2:0] RESET_SEL = 3'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sel_in,
  input  logic       enable,
  output logic       tick,
  output logic [2:0] sel_active,
  output logic       pending
);

  logic [6:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;
  logic [2:0] sel_active_q, sel_active_d;
  logic [2:0] sel_acc;
  logic [6:0] terminal;
  logic [7:0] ratio;
  logic       wrap;

`ifdef ULIGHT_TXCLK_DIV_DEBOUNCE_EN
  logic [2:0] sel_q;
  logic [1:0] stab_q, stab_d;
  logic [2:0] sel_acc_q, sel_acc_d;

  // sel_acc follows sel_in once the same value has been sampled on 4 consecutive edges.
  always_comb begin
    stab_d    = stab_q;
    sel_acc_d = sel_acc_q;
    if (sel_in != sel_q) begin
      stab_d = 2'd0;
    end else begin
      if (stab_q != 2'd3) stab_d = stab_q + 2'd1;
      if (stab_q == 2'd2) sel_acc_d = sel_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= RESET_SEL;
      stab_q    <= 2'd3;
      sel_acc_q <= RESET_SEL;
    end else begin
      sel_q     <= sel_in;
      stab_q    <= stab_d;
      sel_acc_q <= sel_acc_d;
    end
  end

  assign sel_acc = sel_acc_q;
`else
  assign sel_acc = sel_in;
`endif

  assign ratio    = 8'd1 << sel_active_q;
  assign terminal = 7'(ratio - 8'd1);
  assign wrap     = enable && (cnt_q == terminal);

  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    sel_active_d = sel_active_q;
    if (enable) begin
      if (wrap) begin
        cnt_d        = 7'd0;
        tick_d       = 1'b1;
        sel_active_d = sel_acc;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end else if (sel_acc != sel_active_q) begin
      // Frozen divider: no period in flight to protect, so switch immediately.
      cnt_d        = 7'd0;
      sel_active_d = sel_acc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= 7'd0;
      tick_q       <= 1'b0;
      sel_active_q <= RESET_SEL;
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      sel_active_q <= sel_active_d;
    end
  end

  assign tick       = tick_q;
  assign sel_active = sel_active_q;
  assign pending    = (sel_acc != sel_active_q);

endmodule

// File: tb/tb_ulight_fifo_txclk_div.sv
// Directed bench for ulight_fifo_txclk_div: reset, /1, /8, switch at wrap, enable freeze,
// mid-period reset, and the debounce build when ULIGHT_TXCLK_DIV_DEBOUNCE_EN is defined.
module tb_ulight_fifo_txclk_div;

  localparam logic [2:0] RST_SEL = 3'd0;

  logic       clk;
  logic       reset_n;
  logic [2:0] sel_in;
  logic       enable;
  logic       tick;
  logic [2:0] sel_active;
  logic       pending;

  int checks = 0;
  int errors = 0;

  ulight_fifo_txclk_div #(
    .RESET_SEL(RST_SEL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel_in    (sel_in),
    .enable    (enable),
    .tick      (tick),
    .sel_active(sel_active),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sel_in  = 3'd0;
    enable  = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tick !== 1'b0) begin
        errors++; $display("FAIL reset_tick: got %b want 0", tick);
      end
      checks++;
      if (sel_active !== RST_SEL) begin
        errors++; $display("FAIL reset_sel: got %0d want %0d", sel_active, RST_SEL);
      end
      checks++;
      if (pending !== 1'b0) begin
        errors++; $display("FAIL reset_pending: got %b want 0", pending);
      end
      step();
    end
  endtask

  task automatic test_div1();
    sel_in  = 3'd0;
    enable  = 1'b1;
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (tick !== 1'b1 || sel_active !== 3'd0 || pending !== 1'b0) begin
        errors++;
        $display("FAIL div1 cycle %0d: got tick=%b sel=%0d pend=%b want 1/0/0",
                 i, tick, sel_active, pending);
      end
    end
  endtask

  task automatic test_div8();
    sel_in = 3'd3;
    #1;
    checks++;
    if (pending !== 1'b1) begin
      errors++; $display("FAIL div8_pending: got %b want 1", pending);
    end
    step();  // divide-by-1 wraps every cycle, so the switch lands here
    checks++;
    if (sel_active !== 3'd3 || tick !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL div8_switch: got sel=%0d tick=%b pend=%b want 3/1/0",
               sel_active, tick, pending);
    end
    for (int i = 1; i <= 128; i++) begin
      step();
      checks++;
      if (tick !== ((i % 8) == 0)) begin
        errors++; $display("FAIL div8 cycle %0d: got tick=%b want %b", i, tick, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_switch_at_wrap();
    int pend_cycles;
    // Currently sel 3 at cnt=0; request 2, applied at the next wrap 8 clocks later.
    sel_in = 3'd2;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (sel_active !== ((i == 8) ? 3'd2 : 3'd3) || tick !== (i == 8)) begin
        errors++;
        $display("FAIL to_sel2 cycle %0d: got sel=%0d tick=%b", i, sel_active, tick);
      end
    end
    step();  // cnt=1
    step();  // cnt=2; request taken after the cnt=1 edge
    sel_in = 3'd5;
    pend_cycles = 0;
    #1;
    if (pending === 1'b1) pend_cycles++;
    step();  // cnt=3
    if (pending === 1'b1) pend_cycles++;
    checks++;
    if (pend_cycles != 2) begin
      errors++; $display("FAIL switch_pending_len: got %0d want 2", pend_cycles);
    end
    step();  // wrap edge applies sel 5
    checks++;
    if (sel_active !== 3'd5 || tick !== 1'b1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL switch_apply: got sel=%0d tick=%b pend=%b want 5/1/0",
               sel_active, tick, pending);
    end
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (tick !== (i == 32)) begin
        errors++; $display("FAIL div32 cycle %0d: got tick=%b want %b", i, tick, i == 32);
      end
    end
  endtask

  task automatic test_enable_freeze();
    sel_in = 3'd4;
    for (int i = 1; i <= 32; i++) step();
    checks++;
    if (sel_active !== 3'd4 || tick !== 1'b1) begin
      errors++; $display("FAIL to_sel4: got sel=%0d tick=%b want 4/1", sel_active, tick);
    end
    for (int i = 0; i < 3; i++) step();  // cnt=3
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || sel_active !== 3'd4) begin
        errors++; $display("FAIL freeze %0d: got tick=%b sel=%0d want 0/4", i, tick, sel_active);
      end
    end
    enable = 1'b1;
    for (int i = 1; i <= 13; i++) begin  // 3 + 13 = 16 enabled clocks
      step();
      checks++;
      if (tick !== (i == 13)) begin
        errors++; $display("FAIL resume cycle %0d: got tick=%b want %b", i, tick, i == 13);
      end
    end
    enable = 1'b0;
    sel_in = 3'd1;
    step();
    checks++;
    if (sel_active !== 3'd1 || tick !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL idle_switch: got sel=%0d tick=%b pend=%b want 1/0/0",
               sel_active, tick, pending);
    end
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tick !== ((i % 2) == 0)) begin
        errors++; $display("FAIL div2 cycle %0d: got tick=%b want %b", i, tick, (i % 2) == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel_in = 3'd3;
    step();  // cnt 0 -> 1 at sel 1
    step();  // wrap: sel 3
    checks++;
    if (sel_active !== 3'd3 || tick !== 1'b1) begin
      errors++; $display("FAIL pre_reset_sel: got sel=%0d tick=%b want 3/1", sel_active, tick);
    end
    for (int i = 0; i < 5; i++) step();  // cnt=5
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0 || sel_active !== RST_SEL) begin
      errors++;
      $display("FAIL mid_reset: got tick=%b sel=%0d want 0/%0d", tick, sel_active, RST_SEL);
    end
    step();
    reset_n = 1'b1;
    step();  // /1 wraps immediately and applies the pending sel 3
    checks++;
    if (tick !== 1'b1 || sel_active !== 3'd3) begin
      errors++; $display("FAIL post_reset: got tick=%b sel=%0d want 1/3", tick, sel_active);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (tick !== (i == 8)) begin
        errors++; $display("FAIL post_reset cycle %0d: got tick=%b want %b", i, tick, i == 8);
      end
    end
  endtask

  task automatic test_debounce();
    bit seen;
    reset_n = 1'b0;
    sel_in  = 3'd2;
    enable  = 1'b1;
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (sel_active !== RST_SEL || pending !== 1'b0) begin
        errors++;
        $display("FAIL db_settle %0d: got sel=%0d pend=%b", i, sel_active, pending);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (sel_active === 3'd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL db_apply2: got sel=%0d want 2", sel_active);
    end
    sel_in = 3'd6;
    step();
    step();
    sel_in = 3'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (sel_active !== 3'd2 || pending !== 1'b0) begin
        errors++;
        $display("FAIL db_glitch %0d: got sel=%0d pend=%b want 2/0", i, sel_active, pending);
      end
    end
    sel_in = 3'd6;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (pending !== 1'b0) begin
      errors++; $display("FAIL db_early: got pend=%b want 0", pending);
    end
    step();
    checks++;
    if (pending !== 1'b1 || sel_active !== 3'd2) begin
      errors++; $display("FAIL db_pending: got pend=%b sel=%0d want 1/2", pending, sel_active);
    end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      if (sel_active === 3'd6) seen = 1'b1;
    end
    checks++;
    if (!seen || tick !== 1'b1) begin
      errors++; $display("FAIL db_apply6: got sel=%0d tick=%b want 6/1", sel_active, tick);
    end
  endtask

  initial begin
    test_reset();
`ifdef ULIGHT_TXCLK_DIV_DEBOUNCE_EN
    test_debounce();
`else
    test_div1();
    test_div8();
    test_switch_at_wrap();
    test_enable_freeze();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
